// File: rtl/data_mem_responder_pkg.sv
// Shared types and default widths for the data-memory responder.
package data_mem_responder_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WAIT_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: single-port word storage with synchronous write and registered read.
// Contents start at zero and are never cleared by rst; only the read register resets.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wrWord,
  output logic [WORD_W-1:0] rdWord
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] memR [DEPTH] = '{default: '0};
  logic [WORD_W-1:0] rdWordR;

  // Array write port
  always_ff @(posedge clock) begin
    if (wrEn) begin
      memR[addr] <= wrWord;
    end
  end

  // Read register, held between reads
  always_ff @(posedge clock) begin
    if (rst) begin
      rdWordR <= '0;
    end else if (rdEn) begin
      rdWordR <= memR[addr];
    end
  end

  assign rdWord = rdWordR;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-state FSM in front of dmem_array.
// Optional stored even parity is enabled by defining DMEM_PARITY_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              parInject,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              reqErr,
  output logic              parErr
);

`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic       HAS_WAIT = (WAIT_CYC > 32'sd0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYC - 32'sd1) : 4'd0;

  function automatic logic evenPar(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_e            stateR, nextStateS;
  op_e               opR;
  logic [3:0]        cntR, nextCntS;
  logic [ADDR_W-1:0] addrR, arrAddrS;
  logic [WORD_W-1:0] wordR, newWordS, rdWordS;
  logic              readyR, busyR, reqErrR;
  logic              acceptS, conflictS, wrEnS, rdEnS;

  // Next-state, wait counter and array control
  always_comb begin
    nextStateS = stateR;
    nextCntS   = cntR;
    acceptS    = 1'b0;
    conflictS  = 1'b0;
    case (stateR)
      ST_IDLE: begin
        acceptS   = memRead ^ memWrite;
        conflictS = memRead & memWrite;
        if (acceptS && HAS_WAIT) begin
          nextStateS = ST_WAIT;
          nextCntS   = CNT_LOAD;
        end else if (acceptS) begin
          nextStateS = ST_RESP;
        end else begin
          nextStateS = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cntR == 4'd0) begin
          nextStateS = ST_RESP;
        end else begin
          nextCntS = cntR - 4'd1;
        end
      end
      ST_RESP: nextStateS = ST_IDLE;
      default: nextStateS = ST_IDLE;
    endcase

    // A zero-wait read is issued straight from the request inputs
    arrAddrS = (stateR == ST_IDLE) ? addr : addrR;
    rdEnS    = ~rst && (nextStateS == ST_RESP) &&
               (((stateR == ST_IDLE) && memRead) || ((stateR == ST_WAIT) && (opR == OP_RD)));
    wrEnS    = ~rst && (stateR == ST_RESP) && (opR == OP_WR);
  end

`ifdef DMEM_PARITY_EN
  assign newWordS = {evenPar(wdata) ^ parInject, wdata};
  assign parErr   = readyR && (opR == OP_RD) && (^rdWordS);
`else
  logic unusedParInject;
  assign newWordS        = wdata;
  assign parErr          = 1'b0;
  assign unusedParInject = parInject ^ evenPar(wdata);
`endif

  // State, request latch and registered status outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      stateR  <= ST_IDLE;
      cntR    <= 4'd0;
      opR     <= OP_RD;
      addrR   <= '0;
      wordR   <= '0;
      readyR  <= 1'b0;
      busyR   <= 1'b0;
      reqErrR <= 1'b0;
    end else begin
      stateR  <= nextStateS;
      cntR    <= nextCntS;
      readyR  <= (nextStateS == ST_RESP);
      busyR   <= (nextStateS != ST_IDLE);
      reqErrR <= conflictS;
      if (acceptS) begin
        opR   <= memWrite ? OP_WR : OP_RD;
        addrR <= addr;
        wordR <= newWordS;
      end
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) uArray (
    .clock (clock),
    .rst   (rst),
    .wrEn  (wrEnS),
    .rdEn  (rdEnS),
    .addr  (arrAddrS),
    .wrWord(wordR),
    .rdWord(rdWordS)
  );

  assign rdata  = rdWordS[DATA_W-1:0];
  assign ready  = readyR;
  assign busy   = busyR;
  assign reqErr = reqErrR;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with WAIT_CYC=2, one with WAIT_CYC=0.
module tb_data_mem_responder;

  localparam int WC = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst;
  logic       aRead, aWrite, aInj, aReady, aBusy, aReqErr, aParErr;
  logic [7:0] aAddr, aWdata, aRdata;
  logic       bRead, bWrite, bInj, bReady, bBusy, bReqErr, bParErr;
  logic [7:0] bAddr, bWdata, bRdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] modelA [256];
  logic       modelInjA [256];
  logic [7:0] modelB [256];
  logic [7:0] expQ [$];
  logic       expParQ [$];

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(WC)) dutA (
    .clock(clock), .rst(rst), .memRead(aRead), .memWrite(aWrite), .addr(aAddr),
    .wdata(aWdata), .parInject(aInj), .rdata(aRdata), .ready(aReady), .busy(aBusy),
    .reqErr(aReqErr), .parErr(aParErr));

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(0)) dutB (
    .clock(clock), .rst(rst), .memRead(bRead), .memWrite(bWrite), .addr(bAddr),
    .wdata(bWdata), .parInject(bInj), .rdata(bRdata), .ready(bReady), .busy(bBusy),
    .reqErr(bReqErr), .parErr(bParErr));

  // One access on dutA, checking busy/ready timing cycle by cycle
  task automatic accessA(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic inj, input logic scramble);
    logic [7:0] expD;
    logic       expP;
    @(negedge clock);
    aRead = rd; aWrite = wr; aAddr = a; aWdata = d; aInj = inj;
    if (rd) begin
      expQ.push_back(modelA[a]);
`ifdef DMEM_PARITY_EN
      expParQ.push_back(modelInjA[a]);
`else
      expParQ.push_back(1'b0);
`endif
    end
    @(posedge clock);
    @(negedge clock);
    aRead = 1'b0; aWrite = 1'b0;
    for (int k = 1; k <= WC + 1; k++) begin
      if (scramble) begin
        aAddr  = 8'($urandom);
        aWdata = 8'($urandom);
      end
      checks++;
      if (aBusy !== 1'b1) begin
        errors++; $display("FAIL busyA k=%0d got=%b want=1", k, aBusy);
      end
      checks++;
      if (aReady !== (k == WC + 1)) begin
        errors++; $display("FAIL readyA k=%0d got=%b want=%b", k, aReady, (k == WC + 1));
      end
      if ((k == WC + 1) && rd) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL scoreboardA empty at ready, addr=%h", a);
        end else begin
          expD = expQ.pop_front();
          expP = expParQ.pop_front();
          if (aRdata !== expD) begin
            errors++; $display("FAIL rdataA addr=%h got=%h want=%h", a, aRdata, expD);
          end
          checks++;
          if (aParErr !== expP) begin
            errors++; $display("FAIL parErrA addr=%h got=%b want=%b", a, aParErr, expP);
          end
        end
      end else begin
        checks++;
        if (aParErr !== 1'b0) begin
          errors++; $display("FAIL parErrIdleA k=%0d got=%b want=0", k, aParErr);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (aBusy !== 1'b0 || aReady !== 1'b0) begin
      errors++; $display("FAIL doneA busy=%b ready=%b want 0/0", aBusy, aReady);
    end
    if (wr) begin
      modelA[a]    = d;
      modelInjA[a] = inj;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aRead = 1'b0; aWrite = 1'b0; aAddr = 8'h00; aWdata = 8'h00; aInj = 1'b0;
    bRead = 1'b0; bWrite = 1'b0; bAddr = 8'h00; bWdata = 8'h00; bInj = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({aReady, aBusy, aReqErr, aParErr, aRdata} !== 12'h000) begin
      errors++; $display("FAIL resetA got r=%b b=%b e=%b p=%b d=%h want all 0",
                         aReady, aBusy, aReqErr, aParErr, aRdata);
    end
    checks++;
    if ({bReady, bBusy, bReqErr, bParErr, bRdata} !== 12'h000) begin
      errors++; $display("FAIL resetB got r=%b b=%b e=%b p=%b d=%h want all 0",
                         bReady, bBusy, bReqErr, bParErr, bRdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    accessA(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
    accessA(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    accessA(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0);
    accessA(1'b0, 1'b1, 8'hFF, 8'h96, 1'b0, 1'b0);
    accessA(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_req_err();
    @(negedge clock);
    aRead = 1'b1; aWrite = 1'b1; aAddr = 8'h10; aWdata = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    aRead = 1'b0; aWrite = 1'b0;
    checks++;
    if (aReqErr !== 1'b1 || aBusy !== 1'b0 || aReady !== 1'b0) begin
      errors++; $display("FAIL reqErr pulse got e=%b b=%b r=%b want 1/0/0", aReqErr, aBusy, aReady);
    end
    @(negedge clock);
    checks++;
    if (aReqErr !== 1'b0 || aBusy !== 1'b0) begin
      errors++; $display("FAIL reqErr end got e=%b b=%b want 0/0", aReqErr, aBusy);
    end
    accessA(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    accessA(1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0);
    @(negedge clock);
    aWrite = 1'b1; aAddr = 8'h20; aWdata = 8'h3C;
    @(posedge clock);
    @(negedge clock);
    aWrite = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    checks++;
    if (aBusy !== 1'b0 || aReady !== 1'b0 || aRdata !== 8'h00) begin
      errors++; $display("FAIL abort got b=%b r=%b d=%h want 0/0/00", aBusy, aReady, aRdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (aReady !== 1'b0) begin
        errors++; $display("FAIL abortReady i=%0d got=%b want=0", i, aReady);
      end
    end
    accessA(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_latch();
    accessA(1'b0, 1'b1, 8'h40, 8'h77, 1'b0, 1'b1);
    accessA(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    aRead = 1'b1; aAddr = 8'h10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 12) aRead = 1'b0;
      checks++;
      if (aReady !== (c % 4 == 3) || aBusy !== (c % 4 != 0)) begin
        errors++; $display("FAIL held c=%0d ready=%b busy=%b want %b/%b",
                           c, aReady, aBusy, (c % 4 == 3), (c % 4 != 0));
      end
      if (c % 4 == 3) begin
        checks++;
        if (aRdata !== modelA[8'h10]) begin
          errors++; $display("FAIL heldData c=%0d got=%h want=%h", c, aRdata, modelA[8'h10]);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (aBusy !== 1'b0) begin
      errors++; $display("FAIL heldEnd busy got=%b want=0", aBusy);
    end
  endtask

  // One access on the zero-wait instance
  task automatic accessB(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] expD;
    @(negedge clock);
    bRead = rd; bWrite = wr; bAddr = a; bWdata = d;
    if (rd) expQ.push_back(modelB[a]);
    @(posedge clock);
    @(negedge clock);
    bRead = 1'b0; bWrite = 1'b0;
    checks++;
    if (bReady !== 1'b1 || bBusy !== 1'b1 || bParErr !== 1'b0) begin
      errors++; $display("FAIL readyB got r=%b b=%b p=%b want 1/1/0", bReady, bBusy, bParErr);
    end
    if (rd) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++; $display("FAIL scoreboardB empty at ready, addr=%h", a);
      end else begin
        expD = expQ.pop_front();
        if (bRdata !== expD) begin
          errors++; $display("FAIL rdataB addr=%h got=%h want=%h", a, bRdata, expD);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (bReady !== 1'b0 || bBusy !== 1'b0) begin
      errors++; $display("FAIL doneB got r=%b b=%b want 0/0", bReady, bBusy);
    end
    if (wr) modelB[a] = d;
  endtask

  task automatic test_wait0();
    accessB(1'b1, 1'b0, 8'h10, 8'h00);
    accessB(1'b0, 1'b1, 8'h10, 8'h5C);
    accessB(1'b1, 1'b0, 8'h10, 8'h00);
    accessB(1'b0, 1'b1, 8'h11, 8'hC3);
    accessB(1'b1, 1'b0, 8'h11, 8'h00);
  endtask

  task automatic test_parity();
    accessA(1'b0, 1'b1, 8'h50, 8'h5A, 1'b1, 1'b0);
    accessA(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    accessA(1'b0, 1'b1, 8'h51, 8'h5A, 1'b0, 1'b0);
    accessA(1'b1, 1'b0, 8'h51, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      modelA[i] = 8'h00; modelInjA[i] = 1'b0; modelB[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_req_err();
    test_reset_abort();
    test_latch();
    test_back_to_back();
    test_wait0();
    test_parity();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL scoreboard leftover got=%0d want=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-003 SHALL have parameter WAIT_CYC, default 2, meaning wait states inserted per access (legal 0..15).
REQ-004 SHALL have port clock  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port memRead  in  1  read request level from controller.
REQ-007 SHALL have port memWrite  in  1  write request level from controller.
REQ-008 SHALL have port addr  in  ADDR_W  access address.
REQ-009 SHALL have port wdata  in  DATA_W  write data.
REQ-010 SHALL have port parInject  in  1  test-only; flips stored parity bit on write (parity build only).
REQ-011 SHALL have port rdata  out  DATA_W  read data, held until next read completes.
REQ-012 SHALL have port ready  out  1  one-cycle access-complete pulse.
REQ-013 SHALL have port busy  out  1  high while an access is in flight.
REQ-014 SHALL have port reqErr  out  1  one-cycle pulse: memRead and memWrite both high at accept.
REQ-015 SHALL have port parErr  out  1  parity mismatch, valid with ready on reads.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP.
REQ-017 IDLE: memRead xor memWrite high at edge T SHALL latch addr, wdata, op and enter WAIT (WAIT_CYC>0) or RESP (WAIT_CYC=0).
REQ-018 IDLE: both high SHALL pulse reqErr at T+1, perform no access, remain IDLE.
REQ-019 WAIT SHALL count down a 4-bit counter loaded with WAIT_CYC-1; at zero enter RESP.
REQ-020 RESP SHALL assert ready for exactly one cycle, at T+WAIT_CYC+1, then return to IDLE.
REQ-021 Write SHALL commit to the array on the RESP cycle edge using latched addr/wdata; earlier changes of addr/wdata SHALL be ignored.
REQ-022 Read SHALL drive rdata from latched addr, registered, valid in the ready cycle.
REQ-023 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-024 memRead/memWrite SHALL be ignored in WAIT and RESP; a held level gives one access every WAIT_CYC+2 cycles.
REQ-025 Address SHALL index the full 2^ADDR_W words; no wrap or out-of-range case exists.
REQ-026 Read of a never-written word SHALL return X-free zero after array initialisation at time zero.

Reset
REQ-027 rst SHALL force IDLE, counter 0, ready 0, busy 0, reqErr 0, parErr 0, rdata 0.
REQ-028 rst during WAIT or RESP SHALL abort: no write commits, no ready pulse.
REQ-029 rst SHALL NOT clear array contents.

Configuration
REQ-030 Macro DMEM_PARITY_EN defined: array SHALL store DATA_W+1 bits, even parity generated on write (inverted when parInject high), checked on read; parErr = mismatch in ready cycle of reads, else 0.
REQ-031 Macro undefined: array DATA_W bits, parErr tied 0, parInject unused; ports unchanged.

Structure
REQ-032 Shared package SHALL hold FSM state enum, op encoding (OP_RD, OP_WR) and default width constants.
REQ-033 Storage SHALL be sub-module dmem_array (single-port, synchronous write, registered read); FSM and parity in top.

Verification
REQ-034 WAIT_CYC=2: memWrite addr=0x10 wdata=0xA5 at T -> ready at T+3, busy T+1..T+3; then memRead addr=0x10 -> rdata=0xA5 at ready.
REQ-035 WAIT_CYC=0: memRead addr=0x10 at T -> ready and rdata valid at T+1.
REQ-036 memRead and memWrite both high -> reqErr pulse, busy stays 0, addr contents unchanged.
REQ-037 memWrite addr=0x20 wdata=0x3C, rst at T+2 -> no ready; subsequent read of 0x20 returns prior value.
REQ-038 addr/wdata changed during WAIT -> write lands at originally latched address/data.
REQ-039 DMEM_PARITY_EN: write 0x5A with parInject=1, read back -> rdata=0x5A, parErr=1; without parInject parErr=0.
